// File: rtl/cam_link_pkg.sv
// Shared CameraLink Base definitions: TX state encoding, control-bit positions
// and the 28-bit word mapping shared by the transmitter and the receive parser.
package cam_link_pkg;

  localparam int unsigned CAM_WORD_W = 28;
  localparam int unsigned PORT_W     = 8;

  localparam int unsigned LVAL_BIT = 24;
  localparam int unsigned FVAL_BIT = 25;
  localparam int unsigned DVAL_BIT = 26;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } cam_tx_state_e;

  // Map ports A/B/C and the three valids into the Base-config word; pixel bits forced to 0 without DVAL.
  function automatic logic [CAM_WORD_W-1:0] pack_cam_word(
    input logic              lval,
    input logic              fval,
    input logic              dval,
    input logic [PORT_W-1:0] a,
    input logic [PORT_W-1:0] b,
    input logic [PORT_W-1:0] c
  );
    logic [CAM_WORD_W-1:0] w;
    logic [PORT_W-1:0]     pa;
    logic [PORT_W-1:0]     pb;
    logic [PORT_W-1:0]     pc;
    pa = dval ? a : '0;
    pb = dval ? b : '0;
    pc = dval ? c : '0;
    w  = '0;
    w[4:0]   = pa[4:0];
    w[6]     = pa[5];
    w[27]    = pa[6];
    w[5]     = pa[7];
    w[9:7]   = pb[2:0];
    w[14:12] = pb[5:3];
    w[10]    = pb[6];
    w[11]    = pb[7];
    w[15]    = pc[0];
    w[22:18] = pc[5:1];
    w[16]    = pc[6];
    w[17]    = pc[7];
    w[LVAL_BIT] = lval;
    w[FVAL_BIT] = fval;
    w[DVAL_BIT] = dval;
    return w;
  endfunction

endpackage

// File: rtl/cam_data_packer.sv
// Combinational packing of pixel ports and LVAL/FVAL/DVAL into the CameraLink word.
module cam_data_packer
  import cam_link_pkg::*;
(
  input  logic                  lval,
  input  logic                  fval,
  input  logic                  dval,
  input  logic [PORT_W-1:0]     port_a,
  input  logic [PORT_W-1:0]     port_b,
  input  logic [PORT_W-1:0]     port_c,
  output logic [CAM_WORD_W-1:0] cam_word_c
);

  // Bit mapping lives in the package so the receiver uses the identical table.
  always_comb begin
    cam_word_c = pack_cam_word(lval, fval, dval, port_a, port_b, port_c);
  end

endmodule

// File: rtl/axis_cam_tx.sv
// AXI4-Stream video to CameraLink Base transmitter with FVAL/LVAL/DVAL framing
// and programmable setup/blanking. Optional macro AXIS_CAM_TX_STATS_EN adds
// frame_count and underflow_count outputs.
module axis_cam_tx
  import cam_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 24,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned LINES_PER_FRAME = 480,
  parameter int unsigned FV_SETUP        = 4,
  parameter int unsigned HBLANK          = 16,
  parameter int unsigned VBLANK          = 64
) (
  input  logic                  cam_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [CAM_WORD_W-1:0] cam_data_out,
  output logic                  underflow,
  output logic                  frame_err
`ifdef AXIS_CAM_TX_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [15:0]           underflow_count
`endif
);

  localparam int unsigned CNT_W = 16;
  // The IDLE->SETUP transition cycle already drives FVAL, so SETUP itself spans FV_SETUP-1 cycles.
  localparam logic [CNT_W-1:0] SETUP_LOAD  = 16'(FV_SETUP - 2);
  localparam logic [CNT_W-1:0] HBLANK_LOAD = 16'(HBLANK - 1);
  localparam logic [CNT_W-1:0] VBLANK_LOAD = 16'(VBLANK - 1);
  localparam logic [CNT_W-1:0] LINES_LAST  = 16'(LINES_PER_FRAME);

  cam_tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      line_cnt_q, line_cnt_d;
  logic                  started_q, started_d;
  logic [CAM_WORD_W-1:0] cam_data_q, cam_data_d;
  logic                  underflow_q, underflow_d;
  logic                  frame_err_q, frame_err_d;

  logic                  tready_c;
  logic                  sof;
  logic                  abort;
  logic                  line_hs;
  logic                  gap;
  logic [CNT_W-1:0]      line_cnt_inc;
  logic                  lval_d, fval_d, dval_d;

  // Next-state, handshake and per-cycle control-bit decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_cnt_d   = line_cnt_q;
    started_d    = started_q;
    underflow_d  = 1'b0;
    frame_err_d  = 1'b0;
    tready_c     = 1'b0;
    line_hs      = 1'b0;
    gap          = 1'b0;
    abort        = 1'b0;
    sof          = s_axis_tuser[0];
    line_cnt_inc = line_cnt_q + 16'd1;

    unique case (state_q)
      ST_IDLE: begin
        // Stray beats are drained; a start-of-frame beat is held for LINE.
        tready_c = !sof;
        if (s_axis_tvalid) begin
          if (sof) begin
            line_cnt_d = '0;
            started_d  = 1'b0;
            if (FV_SETUP > 1) begin
              state_d = ST_SETUP;
              cnt_d   = SETUP_LOAD;
            end else begin
              state_d = ST_LINE;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) state_d = ST_LINE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      ST_LINE: begin
        abort    = s_axis_tvalid && sof && ((line_cnt_q != '0) || started_q);
        tready_c = !abort;
        if (abort) begin
          frame_err_d = 1'b1;
          started_d   = 1'b0;
          state_d     = ST_VBLANK;
          cnt_d       = VBLANK_LOAD;
        end else if (s_axis_tvalid) begin
          line_hs   = 1'b1;
          started_d = 1'b1;
          if (s_axis_tlast) begin
            started_d  = 1'b0;
            line_cnt_d = line_cnt_inc;
            if (line_cnt_inc == LINES_LAST) begin
              state_d = ST_VBLANK;
              cnt_d   = VBLANK_LOAD;
            end else begin
              state_d = ST_HBLANK;
              cnt_d   = HBLANK_LOAD;
            end
          end
        end else if (started_q) begin
          gap         = 1'b1;
          underflow_d = 1'b1;
        end
      end
      ST_HBLANK: begin
        if (cnt_q == '0) state_d = ST_LINE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      ST_VBLANK: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rst) tready_c = 1'b0;

    dval_d = line_hs;
    lval_d = line_hs || gap;
    fval_d = lval_d || (state_d inside {ST_SETUP, ST_LINE, ST_HBLANK});
  end

  cam_data_packer u_packer (
    .lval       (lval_d),
    .fval       (fval_d),
    .dval       (dval_d),
    .port_a     (s_axis_tdata[7:0]),
    .port_b     (s_axis_tdata[15:8]),
    .port_c     (s_axis_tdata[23:16]),
    .cam_word_c (cam_data_d)
  );

  // State, counters and the registered output word.
  always_ff @(posedge cam_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      line_cnt_q  <= '0;
      started_q   <= 1'b0;
      cam_data_q  <= '0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_cnt_q  <= line_cnt_d;
      started_q   <= started_d;
      cam_data_q  <= cam_data_d;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign s_axis_tready = tready_c;
  assign cam_data_out  = cam_data_q;
  assign underflow     = underflow_q;
  assign frame_err     = frame_err_q;

`ifdef AXIS_CAM_TX_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] underflow_count_q, underflow_count_d;

  // Frames counted on VBLANK entry (normal end or abort); underflows saturate.
  always_comb begin
    frame_count_d     = frame_count_q;
    underflow_count_d = underflow_count_q;
    if ((state_d == ST_VBLANK) && (state_q != ST_VBLANK)) frame_count_d = frame_count_q + 16'd1;
    if (underflow_d && (underflow_count_q != 16'hFFFF)) underflow_count_d = underflow_count_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge cam_clk) begin
    if (rst) begin
      frame_count_q     <= '0;
      underflow_count_q <= '0;
    end else begin
      frame_count_q     <= frame_count_d;
      underflow_count_q <= underflow_count_d;
    end
  end

  assign frame_count     = frame_count_q;
  assign underflow_count = underflow_count_q;
`endif

endmodule
